// File: rtl/vsim_send_arbiter.sv
// ---------------------------------------------------------------------------
// vsim_send_arbiter
//
// Shares one simulation message-send sink (enq/last/RDY, PipeIn style) between
// NUM_REQ requesters. Arbitration is round-robin at message granularity: the
// winning requester owns the sink until its last beat is accepted. A single
// registered output stage decouples the sink RDY from the requester side.
// A wrapping message counter and a sticky over-length flag are kept for
// bench/debug visibility.
//
// Ports
//   CLK            clock, all state on rising edge
//   nRST           synchronous reset, active high
//   req_enq__ENA   per-requester beat valid
//   req_enq_v      per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_enq_last   per-requester last-beat flag
//   req_enq__RDY   per-requester accept (beat moves on ENA & RDY)
//   out_enq__ENA   beat valid to sink (output buffer occupied)
//   out_enq_v      beat data to sink
//   out_enq_last   last flag to sink
//   out_enq__RDY   sink accept
//   msg_count      messages forwarded (last beats taken by sink), wraps
//   owner          current / most recently granted requester
//   locked         a multi-beat message is in progress
//   err_overlen    sticky: a message reached MAX_BEATS beats without last
// ---------------------------------------------------------------------------
module vsim_send_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req_enq__ENA,
  input  logic [NUM_REQ*WIDTH-1:0]   req_enq_v,
  input  logic [NUM_REQ-1:0]         req_enq_last,
  output logic [NUM_REQ-1:0]         req_enq__RDY,
  output logic                       out_enq__ENA,
  output logic [WIDTH-1:0]           out_enq_v,
  output logic                       out_enq_last,
  input  logic                       out_enq__RDY,
  output logic [31:0]                msg_count,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       locked,
  output logic                       err_overlen
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] BEATS_MAX = CW'(MAX_BEATS);

  // state    | meaning
  // ST_IDLE  | no message open; round-robin pick among requesters with ENA
  // ST_LOCKED| owner_q is mid-message; only the owner may be accepted
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic [IW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [IW-1:0]     owner_q,     owner_d;
  logic              buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0]  buf_data_q,  buf_data_d;
  logic              buf_last_q,  buf_last_d;
  logic [31:0]       msg_count_q, msg_count_d;
  logic [CW-1:0]     beat_cnt_q,  beat_cnt_d;
  logic              err_q,       err_d;

  logic [WIDTH-1:0]  req_data [NUM_REQ];
  logic [IW-1:0]     sel;
  logic              sel_found;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_ok;
  logic              can_accept;
  logic              drain;
  logic              accept;
  logic              acc_last;
  logic [CW-1:0]     beat_next;
  logic [NUM_REQ-1:0] rdy;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data[gi] = req_enq_v[gi*WIDTH +: WIDTH];
  end

  // Round-robin scan starting at rr_ptr_q; first requester with ENA wins.
  always_comb begin
    sel       = rr_ptr_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!sel_found && req_enq__ENA[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    msg_count_d = msg_count_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    beat_next   = beat_cnt_q;

    // The buffer can take a new beat when empty or when it drains this cycle,
    // which gives back-to-back throughput without a bubble.
    can_accept = ~buf_valid_q | out_enq__RDY;
    drain      = buf_valid_q & out_enq__RDY;

    // While locked the owner's RDY does not look at any ENA.
    gnt_idx = (state_q == ST_LOCKED) ? owner_q : sel;
    gnt_ok  = (state_q == ST_LOCKED) | sel_found;

    rdy = '0;
    if (!nRST && gnt_ok && can_accept) begin
      rdy[gnt_idx] = 1'b1;
    end
    accept   = rdy[gnt_idx] & req_enq__ENA[gnt_idx];
    acc_last = req_enq_last[gnt_idx];

    if (drain) begin
      buf_valid_d = 1'b0;
      if (buf_last_q) begin
        msg_count_d = msg_count_q + 32'd1;
      end
    end

    if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = req_data[gnt_idx];
      buf_last_d  = acc_last;
      owner_d     = gnt_idx;

      if (state_q == ST_IDLE) begin
        beat_next = CW'(1);
      end else if (beat_cnt_q == BEATS_MAX) begin
        beat_next = BEATS_MAX;
      end else begin
        beat_next = beat_cnt_q + CW'(1);
      end
      beat_cnt_d = beat_next;

      // Flag only; the message keeps flowing until the requester ends it.
      if ((beat_next == BEATS_MAX) && !acc_last) begin
        err_d = 1'b1;
      end

      if (acc_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = IW'((int'(gnt_idx) + 1) % NUM_REQ);
      end else begin
        state_d  = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      msg_count_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      msg_count_q <= msg_count_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign req_enq__RDY = rdy;
  assign out_enq__ENA = buf_valid_q;
  assign out_enq_v    = buf_data_q;
  assign out_enq_last = buf_last_q;
  assign msg_count    = msg_count_q;
  assign owner        = owner_q;
  assign locked       = (state_q == ST_LOCKED);
  assign err_overlen  = err_q;

endmodule

// File: tb/tb_vsim_send_arbiter.sv
module tb_vsim_send_arbiter;

  localparam int NR   = 4;
  localparam int W    = 32;
  localparam int MAXB = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NR-1:0]   req_ena;
  logic [NR*W-1:0] req_v;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_rdy;
  logic            out_ena;
  logic [W-1:0]    out_v;
  logic            out_last;
  logic            out_rdy;
  logic [31:0]     msg_count;
  logic [1:0]      owner;
  logic            locked;
  logic            err_overlen;

  always #5 CLK = ~CLK;

  vsim_send_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_enq__ENA (req_ena),
    .req_enq_v    (req_v),
    .req_enq_last (req_last),
    .req_enq__RDY (req_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq_last (out_last),
    .out_enq__RDY (out_rdy),
    .msg_count    (msg_count),
    .owner        (owner),
    .locked       (locked),
    .err_overlen  (err_overlen)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-requester beat queues: {last, data}
  logic [W:0] rq_mem [NR][256];
  int         rq_head [NR];
  int         rq_tail [NR];

  bit rst_drive;
  bit gaps_on;
  int sink_mode;   // 0: sink always ready, 1: random, 2: stalled
  int cyc;

  // Reference model: message-level ownership + one-entry output buffer
  bit          m_locked;
  int          m_owner;
  int          m_rr;
  bit          m_bv;
  logic [W-1:0] m_bd;
  bit          m_bl;
  logic [31:0] m_mc;
  int          m_bc;
  bit          m_err;
  logic [NR-1:0] exp_rdy;
  int          m_grant;
  int          glog[$];
  int          glog_t[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic add_msg(input int r, input int len);
    if (rq_head[r] == rq_tail[r]) begin
      rq_head[r] = 0;
      rq_tail[r] = 0;
    end
    for (int b = 0; b < len; b++) begin
      rq_mem[r][rq_tail[r]] = {(b == len - 1), W'($urandom)};
      rq_tail[r]++;
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq_head[i] != rq_tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic m_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_bv = 0; m_bd = '0; m_bl = 0;
    m_mc = '0; m_bc = 0; m_err = 0;
  endtask

  task automatic model_comb();
    bit can;
    int sel;
    can     = !m_bv || out_rdy;
    exp_rdy = '0;
    m_grant = -1;
    sel     = -1;
    if (!rst_drive) begin
      if (m_locked) begin
        if (can) begin
          exp_rdy[m_owner] = 1'b1;
          if (req_ena[m_owner]) m_grant = m_owner;
        end
      end else begin
        for (int k = 0; k < NR; k++)
          if (sel < 0 && req_ena[(m_rr + k) % NR]) sel = (m_rr + k) % NR;
        if (sel >= 0 && can) begin
          exp_rdy[sel] = 1'b1;
          m_grant = sel;
        end
      end
    end
  endtask

  task automatic model_update();
    int g;
    if (rst_drive) begin
      m_reset();
      for (int i = 0; i < NR; i++) rq_head[i] = rq_tail[i];
      return;
    end
    if (m_bv && out_rdy) begin
      if (m_bl) m_mc++;
      m_bv = 0;
    end
    if (m_grant >= 0) begin
      g    = m_grant;
      m_bd = req_v[g*W +: W];
      m_bl = req_last[g];
      m_bv = 1;
      rq_head[g]++;
      if (m_locked) m_bc = (m_bc < MAXB) ? m_bc + 1 : MAXB;
      else          m_bc = 1;
      if (m_bc == MAXB && !m_bl) m_err = 1;
      m_owner = g;
      glog.push_back(g);
      glog_t.push_back(cyc);
      if (m_bl) begin
        m_locked = 0;
        m_rr     = (g + 1) % NR;
      end else begin
        m_locked = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    cyc++;
    nRST = rst_drive;
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq_tail[i]) begin
        req_ena[i]       = !gaps_on || ($urandom_range(3) != 0);
        req_v[i*W +: W]  = rq_mem[i][rq_head[i]][W-1:0];
        req_last[i]      = rq_mem[i][rq_head[i]][W];
      end else begin
        req_ena[i]       = 1'b0;
        req_v[i*W +: W]  = $urandom;
        req_last[i]      = 1'($urandom);
      end
    end
    case (sink_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ($urandom_range(3) != 0);
      default: out_rdy = 1'b0;
    endcase
    #1;
    model_comb();
    chk("req_rdy",   64'(req_rdy),   64'(exp_rdy));
    chk("out_ena",   64'(out_ena),   64'(m_bv));
    if (m_bv) begin
      chk("out_v",    64'(out_v),    64'(m_bd));
      chk("out_last", 64'(out_last), 64'(m_bl));
    end
    chk("msg_count",   64'(msg_count),   64'(m_mc));
    chk("locked",      64'(locked),      64'(m_locked));
    chk("owner",       64'(owner),       64'(m_owner));
    chk("err_overlen", 64'(err_overlen), 64'(m_err));
    model_update();
  endtask

  task automatic reset_pulse();
    rst_drive = 1;
    cycle();
    rst_drive = 0;
  endtask

  task automatic drain_all(input int budget, input string tag);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      cycle();
      done = all_empty() && !m_bv;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  int exp3 [6]  = '{1, 1, 1, 1, 2, 0};
  int exp3b [3] = '{1, 1, 0};
  int exp4 [5]  = '{2, 2, 3, 3, 3};

  initial begin
    rst_drive = 1; gaps_on = 0; sink_mode = 0; cyc = 0;
    nRST = 1'b1; req_ena = '0; req_v = '0; req_last = '0; out_rdy = 1'b0;
    for (int i = 0; i < NR; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
    repeat (3) @(posedge CLK);
    m_reset();

    // Reset state
    cycle();
    chk("rst_out_v",    64'(out_v),    64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    rst_drive = 0;
    cycle();

    // 1: single 3-beat message from req0
    glog.delete(); glog_t.delete();
    add_msg(0, 3);
    drain_all(20, "t1_drain");
    cycle();
    chk("t1_msg_count", 64'(msg_count), 64'd1);
    chk("t1_beats",     64'(glog.size()), 64'd3);

    // 2: full contention, single-beat messages
    reset_pulse();
    glog.delete(); glog_t.delete();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NR; r++) add_msg(r, 1);
    drain_all(20, "t2_drain");
    cycle();
    chk("t2_msg_count", 64'(msg_count), 64'd8);
    chk("t2_grants", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_order", 64'(glog[k]), 64'(k % NR));
      chk("t2_rate",  64'(glog_t[k] - glog_t[0]), 64'(k));
    end

    // 3: req1 holds the sink through a 4-beat message; req2 then req0
    reset_pulse();
    glog.delete(); glog_t.delete();
    add_msg(1, 4);
    cycle();
    add_msg(0, 1);
    add_msg(2, 1);
    drain_all(30, "t3_drain");
    chk("t3_grants", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6; k++) chk("t3_order", 64'(glog[k]), 64'(exp3[k]));
    cycle();
    chk("t3_no_err_at_max", 64'(err_overlen), 64'd0);

    glog.delete(); glog_t.delete();
    add_msg(1, 2);
    cycle();
    add_msg(0, 1);
    drain_all(30, "t3b_drain");
    chk("t3b_grants", 64'(glog.size()), 64'd3);
    for (int k = 0; k < 3; k++) chk("t3b_order", 64'(glog[k]), 64'(exp3b[k]));

    // 4: sink stall with buffer full
    reset_pulse();
    glog.delete(); glog_t.delete();
    add_msg(3, 3);
    add_msg(2, 2);
    cycle();
    sink_mode = 2;
    repeat (5) begin
      cycle();
      chk("t4_stall_rdy", 64'(req_rdy), 64'd0);
    end
    sink_mode = 0;
    drain_all(30, "t4_drain");
    cycle();
    chk("t4_msg_count", 64'(msg_count), 64'd2);
    chk("t4_grants", 64'(glog.size()), 64'd5);
    for (int k = 0; k < 5; k++) chk("t4_order", 64'(glog[k]), 64'(exp4[k]));

    // 5: over-length message, then sticky error
    reset_pulse();
    add_msg(0, 6);
    drain_all(30, "t5_drain");
    cycle();
    chk("t5_err",       64'(err_overlen), 64'd1);
    chk("t5_msg_count", 64'(msg_count),   64'd1);
    add_msg(1, 2);
    drain_all(30, "t5b_drain");
    cycle();
    chk("t5_err_sticky", 64'(err_overlen), 64'd1);
    chk("t5b_msg_count", 64'(msg_count),   64'd2);

    // Randomized traffic with ENA gaps and random sink back-pressure
    reset_pulse();
    gaps_on = 1;
    sink_mode = 1;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++)
        if (rq_head[r] == rq_tail[r] && $urandom_range(2) == 0)
          add_msg(r, $urandom_range(6, 1));
      cycle();
    end
    gaps_on = 0;
    sink_mode = 0;
    drain_all(300, "rand_drain");

    // 6: reset in the middle of a message with the buffer full
    reset_pulse();
    add_msg(1, 1);
    drain_all(20, "t6_pre_drain");
    add_msg(2, 5);
    sink_mode = 2;
    cycle();
    cycle();
    rst_drive = 1;
    cycle();
    rst_drive = 0;
    sink_mode = 0;
    cycle();
    chk("t6_out_ena",   64'(out_ena),   64'd0);
    chk("t6_locked",    64'(locked),    64'd0);
    chk("t6_msg_count", 64'(msg_count), 64'd0);
    chk("t6_out_v",     64'(out_v),     64'd0);
    glog.delete(); glog_t.delete();
    add_msg(3, 1);
    add_msg(0, 1);
    drain_all(20, "t6_drain");
    chk("t6_grants", 64'(glog.size()), 64'd2);
    chk("t6_rr_first",  64'(glog[0]), 64'd0);
    chk("t6_rr_second", 64'(glog[1]), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
